// File: rtl/sdram_arbit.sv
// ----------------------------------------------------------------------------
// sdram_arbit
// Owns the single SDRAM command/address/data bus and lends it to one of four
// sub-blocks at a time: power-up init, auto-refresh, write and read.
//   - Init holds the bus from reset until flag_init_end.
//   - Refresh always wins arbitration.
//   - Write and read alternate round-robin when both are pending.
//   - A granted block keeps the bus until it pulses its own end flag. The
//     arbiter never preempts a block.
//   - Every hand-over passes through at least one NOP cycle in S_ARBIT.
//
// Ports
//   sclk, s_rst_n           clock, asynchronous active-low reset
//   flag_init_end           init sequence done (1-cycle pulse)
//   init_cmd/init_addr      init block bus drive
//   ref_req/flag_ref_end    refresh request level / done pulse
//   ref_cmd/ref_addr        refresh block bus drive
//   ref_en                  refresh grant pulse (registered, 1 cycle)
//   wr_req/flag_wr_end      write request level / release pulse
//   wr_cmd/wr_addr/wr_bank  write block bus drive
//   wr_data                 write data, passed straight to DQ
//   wr_en                   write grant pulse (registered, 1 cycle)
//   rd_req/flag_rd_end      read request level / release pulse
//   rd_cmd/rd_addr/rd_bank  read block bus drive
//   rd_en                   read grant pulse (registered, 1 cycle)
//   sdram_cmd               {cs_n,ras_n,cas_n,we_n} to pins
//   sdram_addr/sdram_bank   address/bank to pins
//   sdram_dq_out/_oe        write data and DQ output enable
// ----------------------------------------------------------------------------
module sdram_arbit #(
  parameter int ADDR_W = 12,
  parameter int BANK_W = 2,
  parameter int DATA_W = 16
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              flag_init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ref_req,
  input  logic              flag_ref_end,
  input  logic [3:0]        ref_cmd,
  input  logic [ADDR_W-1:0] ref_addr,
  output logic              ref_en,
  input  logic              wr_req,
  input  logic              flag_wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              flag_rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic              rd_en,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_AREF  = 5'b00100,
    S_WRITE = 5'b01000,
    S_READ  = 5'b10000
  } state_t;

  localparam logic       LG_RD   = 1'b0;
  localparam logic       LG_WR   = 1'b1;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   last_grant_nxt;
  logic   ref_en_nxt;
  logic   wr_en_nxt;
  logic   rd_en_nxt;

  // State, round-robin pointer and grant pulses
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state      <= S_INIT;
      last_grant <= LG_RD;
      ref_en     <= 1'b0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      ref_en     <= ref_en_nxt;
      wr_en      <= wr_en_nxt;
      rd_en      <= rd_en_nxt;
    end
  end

  // Next state. Grant pulses are decoded from the S_ARBIT exit so that they
  // rise on the same edge the state register enters the granted state.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    ref_en_nxt     = 1'b0;
    wr_en_nxt      = 1'b0;
    rd_en_nxt      = 1'b0;
    case (state)
      S_INIT: begin
        if (flag_init_end) state_nxt = S_ARBIT;
      end
      S_ARBIT: begin
        if (ref_req) begin
          state_nxt  = S_AREF;
          ref_en_nxt = 1'b1;
        end else if (wr_req && (!rd_req || last_grant == LG_RD)) begin
          // Write wins when it is alone, or when both are pending and read
          // was served last.
          state_nxt      = S_WRITE;
          wr_en_nxt      = 1'b1;
          last_grant_nxt = LG_WR;
        end else if (rd_req) begin
          state_nxt      = S_READ;
          rd_en_nxt      = 1'b1;
          last_grant_nxt = LG_RD;
        end
      end
      S_AREF: begin
        if (flag_ref_end) state_nxt = S_ARBIT;
      end
      S_WRITE: begin
        if (flag_wr_end) state_nxt = S_ARBIT;
      end
      S_READ: begin
        if (flag_rd_end) state_nxt = S_ARBIT;
      end
      // Any non-one-hot encoding recovers through the idle arbitration state.
      default: state_nxt = S_ARBIT;
    endcase
  end

  // Bus mux straight from the state register, no added latency
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    case (state)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      S_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
      end
    endcase
  end

  assign sdram_dq_out = wr_data;
  assign sdram_dq_oe  = (state == S_WRITE);

endmodule

// File: tb/tb_sdram_arbit.sv
// ----------------------------------------------------------------------------
// tb_sdram_arbit
// Directed bench for sdram_arbit. Each task drives one scenario and checks
// bus outputs and grant pulses against hand-computed values. Inputs change
// 1 time unit after the rising edge; outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_sdram_arbit;

  localparam int ADDR_W = 12;
  localparam int BANK_W = 2;
  localparam int DATA_W = 16;

  localparam logic [3:0] NOP   = 4'b0111;
  localparam logic [3:0] I_CMD = 4'b0001;
  localparam logic [3:0] F_CMD = 4'b0010;
  localparam logic [3:0] W_CMD = 4'b0100;
  localparam logic [3:0] R_CMD = 4'b0101;
  localparam logic [ADDR_W-1:0] I_ADDR = 12'h400;
  localparam logic [ADDR_W-1:0] F_ADDR = 12'h0AA;
  localparam logic [ADDR_W-1:0] W_ADDR = 12'h123;
  localparam logic [ADDR_W-1:0] R_ADDR = 12'h456;

  logic              sclk = 1'b0;
  logic              s_rst_n;
  logic              flag_init_end;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic              ref_req;
  logic              flag_ref_end;
  logic [3:0]        ref_cmd;
  logic [ADDR_W-1:0] ref_addr;
  logic              ref_en;
  logic              wr_req;
  logic              flag_wr_end;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BANK_W-1:0] wr_bank;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              rd_req;
  logic              flag_rd_end;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BANK_W-1:0] rd_bank;
  logic              rd_en;
  logic [3:0]        sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BANK_W-1:0] sdram_bank;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;

  int errors = 0;
  int checks = 0;

  sdram_arbit #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DATA_W(DATA_W)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .flag_init_end(flag_init_end), .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .flag_ref_end(flag_ref_end), .ref_cmd(ref_cmd),
    .ref_addr(ref_addr), .ref_en(ref_en),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd),
    .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data), .wr_en(wr_en),
    .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd),
    .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 sclk = ~sclk;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  // Reset, then leave S_INIT so the arbiter sits idle in S_ARBIT.
  task automatic do_init();
    s_rst_n = 1'b0;
    step();
    s_rst_n = 1'b1;
    step();
    flag_init_end = 1'b1;
    step();
    flag_init_end = 1'b0;
  endtask

  task automatic test_reset();
    s_rst_n = 1'b0;
    step();
    step();
    checks++; if (sdram_cmd !== I_CMD) begin errors++; $display("FAIL rst_cmd got=%b exp=%b", sdram_cmd, I_CMD); end
    checks++; if (sdram_addr !== I_ADDR) begin errors++; $display("FAIL rst_addr got=%h exp=%h", sdram_addr, I_ADDR); end
    checks++; if ({ref_en, wr_en, rd_en, sdram_dq_oe} !== 4'b0000) begin errors++; $display("FAIL rst_grants got=%b exp=0000", {ref_en, wr_en, rd_en, sdram_dq_oe}); end
    s_rst_n = 1'b1;
    // Requests raised during init must not be granted.
    wr_req = 1'b1;
    rd_req = 1'b1;
    ref_req = 1'b1;
    repeat (5) step();
    checks++; if (sdram_cmd !== I_CMD) begin errors++; $display("FAIL init_hold_cmd got=%b exp=%b", sdram_cmd, I_CMD); end
    checks++; if ({ref_en, wr_en, rd_en} !== 3'b000) begin errors++; $display("FAIL init_no_grant got=%b exp=000", {ref_en, wr_en, rd_en}); end
    wr_req = 1'b0;
    rd_req = 1'b0;
    ref_req = 1'b0;
    flag_init_end = 1'b1;
    step();
    flag_init_end = 1'b0;
    checks++; if (sdram_cmd !== NOP) begin errors++; $display("FAIL init_end_cmd got=%b exp=%b", sdram_cmd, NOP); end
    checks++; if ({sdram_addr, sdram_bank} !== '0) begin errors++; $display("FAIL init_end_addr got=%h/%b exp=0/0", sdram_addr, sdram_bank); end
    step();
    checks++; if ({sdram_cmd, ref_en, wr_en, rd_en} !== {NOP, 3'b000}) begin errors++; $display("FAIL arb_idle got=%b exp=%b", {sdram_cmd, ref_en, wr_en, rd_en}, {NOP, 3'b000}); end
  endtask

  task automatic test_ref_priority();
    ref_req = 1'b1;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    step();
    ref_req = 1'b0;
    checks++; if ({ref_en, wr_en, rd_en} !== 3'b100) begin errors++; $display("FAIL ref_grant got=%b exp=100", {ref_en, wr_en, rd_en}); end
    checks++; if (sdram_cmd !== F_CMD || sdram_addr !== F_ADDR) begin errors++; $display("FAIL ref_bus got=%b/%h exp=%b/%h", sdram_cmd, sdram_addr, F_CMD, F_ADDR); end
    step();
    checks++; if (ref_en !== 1'b0 || sdram_cmd !== F_CMD) begin errors++; $display("FAIL ref_pulse_len got=%b/%b exp=0/%b", ref_en, sdram_cmd, F_CMD); end
    flag_ref_end = 1'b1;
    step();
    flag_ref_end = 1'b0;
    checks++; if ({sdram_cmd, ref_en, wr_en, rd_en} !== {NOP, 3'b000}) begin errors++; $display("FAIL ref_gap got=%b exp=%b", {sdram_cmd, ref_en, wr_en, rd_en}, {NOP, 3'b000}); end
    step();
    checks++; if ({ref_en, wr_en, rd_en} !== 3'b010 || sdram_cmd !== W_CMD) begin errors++; $display("FAIL ref_then_wr got=%b/%b exp=010/%b", {ref_en, wr_en, rd_en}, sdram_cmd, W_CMD); end
    wr_req = 1'b0;
    rd_req = 1'b0;
    flag_wr_end = 1'b1;
    step();
    flag_wr_end = 1'b0;
  endtask

  task automatic test_round_robin();
    logic exp_wr;
    // Last grant was write; a reset must restore read so write goes first.
    do_init();
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    wr_bank = 2'b10;
    rd_bank = 2'b01;
    for (int i = 0; i < 4; i++) begin
      exp_wr = (i % 2 == 0);
      step();
      checks++; if ({wr_en, rd_en, ref_en} !== {exp_wr, !exp_wr, 1'b0}) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, {wr_en, rd_en, ref_en}, {exp_wr, !exp_wr, 1'b0}); end
      checks++; if (sdram_cmd !== (exp_wr ? W_CMD : R_CMD) || sdram_bank !== (exp_wr ? 2'b10 : 2'b01) || sdram_addr !== (exp_wr ? W_ADDR : R_ADDR)) begin errors++; $display("FAIL rr_bus%0d got=%b/%h/%b", i, sdram_cmd, sdram_addr, sdram_bank); end
      checks++; if (sdram_dq_oe !== exp_wr) begin errors++; $display("FAIL rr_oe%0d got=%b exp=%b", i, sdram_dq_oe, exp_wr); end
      step();
      checks++; if ({wr_en, rd_en} !== 2'b00) begin errors++; $display("FAIL rr_pulse%0d got=%b exp=00", i, {wr_en, rd_en}); end
      if (exp_wr) flag_wr_end = 1'b1; else flag_rd_end = 1'b1;
      step();
      flag_wr_end = 1'b0;
      flag_rd_end = 1'b0;
      checks++; if ({sdram_cmd, wr_en, rd_en, sdram_dq_oe} !== {NOP, 3'b000}) begin errors++; $display("FAIL rr_nop%0d got=%b exp=%b", i, {sdram_cmd, wr_en, rd_en, sdram_dq_oe}, {NOP, 3'b000}); end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    wr_bank = 2'b00;
    rd_bank = 2'b00;
    step();
  endtask

  task automatic test_write_dq();
    wr_cmd  = 4'b0100;
    wr_bank = 2'b00;
    wr_data = 16'h0009;
    checks++; if (sdram_dq_out !== 16'h0009 || sdram_dq_oe !== 1'b0) begin errors++; $display("FAIL dq_idle got=%h/%b exp=0009/0", sdram_dq_out, sdram_dq_oe); end
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    checks++; if (sdram_dq_oe !== 1'b1 || sdram_dq_out !== 16'h0009 || sdram_cmd !== 4'b0100 || sdram_bank !== 2'b00) begin errors++; $display("FAIL wr_dq got=%b/%h/%b/%b exp=1/0009/0100/00", sdram_dq_oe, sdram_dq_out, sdram_cmd, sdram_bank); end
    flag_rd_end = 1'b1;
    step();
    flag_rd_end = 1'b0;
    checks++; if (sdram_cmd !== 4'b0100 || sdram_dq_oe !== 1'b1) begin errors++; $display("FAIL wr_ignore_rd_end got=%b/%b exp=0100/1", sdram_cmd, sdram_dq_oe); end
    flag_ref_end = 1'b1;
    step();
    flag_ref_end = 1'b0;
    checks++; if (sdram_cmd !== 4'b0100) begin errors++; $display("FAIL wr_ignore_ref_end got=%b exp=0100", sdram_cmd); end
    flag_wr_end = 1'b1;
    step();
    flag_wr_end = 1'b0;
    checks++; if (sdram_cmd !== NOP || sdram_dq_oe !== 1'b0) begin errors++; $display("FAIL wr_release got=%b/%b exp=%b/0", sdram_cmd, sdram_dq_oe, NOP); end
  endtask

  task automatic test_no_preempt();
    wr_req = 1'b1;
    step();
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL np_wr_grant got=%b exp=1", wr_en); end
    ref_req = 1'b1;
    step();
    step();
    checks++; if (sdram_cmd !== W_CMD || ref_en !== 1'b0) begin errors++; $display("FAIL np_hold got=%b/%b exp=%b/0", sdram_cmd, ref_en, W_CMD); end
    flag_wr_end = 1'b1;
    step();
    flag_wr_end = 1'b0;
    checks++; if (sdram_cmd !== NOP) begin errors++; $display("FAIL np_gap got=%b exp=%b", sdram_cmd, NOP); end
    step();
    ref_req = 1'b0;
    checks++; if ({ref_en, wr_en, rd_en} !== 3'b100 || sdram_cmd !== F_CMD) begin errors++; $display("FAIL np_ref_next got=%b/%b exp=100/%b", {ref_en, wr_en, rd_en}, sdram_cmd, F_CMD); end
    flag_ref_end = 1'b1;
    step();
    flag_ref_end = 1'b0;
    step();
    checks++; if ({ref_en, wr_en, rd_en} !== 3'b010 || sdram_cmd !== W_CMD) begin errors++; $display("FAIL np_wr_again got=%b/%b exp=010/%b", {ref_en, wr_en, rd_en}, sdram_cmd, W_CMD); end
    wr_req = 1'b0;
    flag_wr_end = 1'b1;
    step();
    flag_wr_end = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1'b1;
    step();
    checks++; if (rd_en !== 1'b1 || sdram_cmd !== R_CMD) begin errors++; $display("FAIL mr_rd_grant got=%b/%b exp=1/%b", rd_en, sdram_cmd, R_CMD); end
    s_rst_n = 1'b0;
    #1;
    checks++; if (rd_en !== 1'b0 || sdram_cmd !== I_CMD || sdram_addr !== I_ADDR) begin errors++; $display("FAIL mr_async got=%b/%b/%h exp=0/%b/%h", rd_en, sdram_cmd, sdram_addr, I_CMD, I_ADDR); end
    step();
    s_rst_n = 1'b1;
    rd_req = 1'b0;
    step();
    checks++; if (sdram_cmd !== I_CMD || {ref_en, wr_en, rd_en} !== 3'b000) begin errors++; $display("FAIL mr_stay_init got=%b/%b exp=%b/000", sdram_cmd, {ref_en, wr_en, rd_en}, I_CMD); end
  endtask

  initial begin
    s_rst_n       = 1'b0;
    flag_init_end = 1'b0;
    init_cmd      = I_CMD;
    init_addr     = I_ADDR;
    ref_req       = 1'b0;
    flag_ref_end  = 1'b0;
    ref_cmd       = F_CMD;
    ref_addr      = F_ADDR;
    wr_req        = 1'b0;
    flag_wr_end   = 1'b0;
    wr_cmd        = W_CMD;
    wr_addr       = W_ADDR;
    wr_bank       = 2'b00;
    wr_data       = 16'hBEEF;
    rd_req        = 1'b0;
    flag_rd_end   = 1'b0;
    rd_cmd        = R_CMD;
    rd_addr       = R_ADDR;
    rd_bank       = 2'b00;

    test_reset();
    test_ref_priority();
    test_round_robin();
    test_write_dq();
    test_no_preempt();
    test_reset_mid_read();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
Top-level SDRAM command arbiter. It owns the single SDRAM command/address/data bus and shares it between four sub-blocks: init, auto-refresh, write and read. The first three are sdram_init, the refresh generator and sdram_write; the read engine uses the same req/en/end handshake as sdram_write. Refresh has absolute priority. Write and read alternate round-robin when both are pending. The arbiter muxes the granted block's command, address and bank onto the SDRAM pins.

Parameters:
ADDR_W, 12, SDRAM address width
BANK_W, 2, bank address width
DATA_W, 16, SDRAM data width

Ports:
sclk  in  1  system clock
s_rst_n  in  1  asynchronous active-low reset
flag_init_end  in  1  one-cycle pulse: power-up init sequence done
init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
init_addr  in  ADDR_W  init address
ref_req  in  1  refresh request level (held until granted)
flag_ref_end  in  1  one-cycle pulse: refresh done
ref_cmd  in  4  refresh command
ref_addr  in  ADDR_W  refresh address
ref_en  out  1  refresh grant pulse
wr_req  in  1  write request level
flag_wr_end  in  1  one-cycle pulse: write block released bus
wr_cmd  in  4  write command
wr_addr  in  ADDR_W  write address
wr_bank  in  BANK_W  write bank
wr_data  in  DATA_W  write data
wr_en  out  1  write grant pulse
rd_req  in  1  read request level
flag_rd_end  in  1  one-cycle pulse: read block released bus
rd_cmd  in  4  read command
rd_addr  in  ADDR_W  read address
rd_bank  in  BANK_W  read bank
rd_en  out  1  read grant pulse
sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to pins
sdram_addr  out  ADDR_W  address to pins
sdram_bank  out  BANK_W  bank to pins
sdram_dq_out  out  DATA_W  write data to pins
sdram_dq_oe  out  1  DQ output enable

Behaviour:
- Clock and reset: one clock, sclk. Reset s_rst_n is asynchronous, active-low.
- State register: one-hot, 5 bits.
  - S_INIT=00001, S_ARBIT=00010, S_AREF=00100, S_WRITE=01000, S_READ=10000.
  - Reset value S_INIT. Illegal state goes to S_ARBIT next cycle.
- Transitions:
  - S_INIT -> S_ARBIT on flag_init_end. All requests are ignored in S_INIT.
  - S_ARBIT: ref_req -> S_AREF. Otherwise, if wr_req and rd_req are both set, go to the one not served last. Otherwise wr_req -> S_WRITE, rd_req -> S_READ. Otherwise stay.
  - S_AREF -> S_ARBIT on flag_ref_end.
  - S_WRITE -> S_ARBIT on flag_wr_end.
  - S_READ -> S_ARBIT on flag_rd_end.
  - An end pulse from a block not currently granted is ignored.
  - No preemption: ref_req during S_WRITE/S_READ waits. The sub-block itself breaks off, pulses its end flag and re-raises its req.
- Round-robin: 1-bit last_grant register, reset = read.
  - Set to write on entry to S_WRITE; set to read on entry to S_READ.
  - Consequence: after reset, simultaneous wr_req & rd_req grants write first.
- Grant pulses: ref_en, wr_en, rd_en are registered, reset 0, high exactly one cycle.
  - The pulse is high in the first cycle the state register holds the granted state (asserted on the same edge as the transition).
  - At most one pulse is high at a time.
- Bus mux: combinational from the state register, zero added latency.
  - S_INIT: init_cmd / init_addr, bank 0.
  - S_AREF: ref_cmd / ref_addr, bank 0.
  - S_WRITE: wr_cmd / wr_addr / wr_bank.
  - S_READ: rd_cmd / rd_addr / rd_bank.
  - S_ARBIT: NOP (0111), addr 0, bank 0.
- DQ: sdram_dq_out = wr_data always. sdram_dq_oe = 1 only in S_WRITE.
- Minimum bus hold: S_ARBIT lasts at least one cycle between grants, so a NOP always separates two sub-blocks.
- Reset mid-operation: state returns to S_INIT asynchronously, grant pulses clear to 0, last_grant returns to read, and the outputs show the init bus.

Test Plan:
- Reset, hold requests low, pulse flag_init_end at cycle 10 -> state S_ARBIT at cycle 11, sdram_cmd=0111, no grant pulses. Requests raised before cycle 10 stay ungranted.
- In S_ARBIT, raise ref_req, wr_req and rd_req together -> ref_en pulses 1 cycle, sdram_cmd follows ref_cmd. After flag_ref_end, one idle cycle with NOP, then wr_en pulses (last_grant=read after reset).
- Hold wr_req and rd_req high across 4 grants -> grant order W,R,W,R, each separated by one NOP cycle in S_ARBIT.
- In S_WRITE, drive wr_data=0x0009, wr_cmd=0100, wr_bank=2'b00 -> sdram_dq_oe=1, sdram_dq_out=0x0009, sdram_cmd=0100. Pulse flag_rd_end -> no transition. Pulse flag_wr_end -> S_ARBIT, dq_oe=0.
- In S_WRITE, assert ref_req -> no preemption. Write block pulses flag_wr_end and keeps wr_req high -> next grant is ref_en, then wr_en.
- Assert s_rst_n low mid-S_READ for 1 cycle -> state=S_INIT immediately, rd_en=0, sdram_cmd equals init_cmd.
